// File: rtl/delay_line_pkg.sv
// Shared constants and elaboration helpers for the delay line bank.
// The trim width is fixed here and is only used when DELAY_LINE_TRIM_EN is defined.
package delay_line_pkg;

    localparam int TRIM_W = 4;

    localparam int DEF_CLK_FREQ    = 81_000_000;
    localparam int DEF_BIT_TIME_NS = 1900;
    localparam int DEF_BITS        = 576;

    // Clock cycles per bit period, rounded to nearest.
    function automatic int calc_ticks(input longint clk_freq, input longint bit_time_ns);
        longint num;
        num = clk_freq * bit_time_ns + 64'sd500_000_000;
        return int'(num / 64'sd1_000_000_000);
    endfunction

    // Tick counter width, with headroom for the largest positive trim.
    function automatic int ticks_width(input int ticks);
        return $clog2(ticks + 2 ** (TRIM_W - 1));
    endfunction

    function automatic int ptr_width(input int bits);
        return $clog2(bits);
    endfunction

    localparam int TICKS_W = ticks_width(calc_ticks(DEF_CLK_FREQ, DEF_BIT_TIME_NS));
    localparam int PTR_W   = ptr_width(DEF_BITS);

endpackage

// File: rtl/delay_line_bank_if.sv
// Serial data, recirculate control and timing status of the delay line bank.
// The trim field exists only when DELAY_LINE_TRIM_EN is defined.
interface delay_line_bank_if #(
    parameter int CHANNELS = 4
);
    import delay_line_pkg::*;

    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] recirc;
    logic [CHANNELS-1:0] out;
    logic                bit_strobe;
    logic                frame_start;
    logic                primed;

`ifdef DELAY_LINE_TRIM_EN
    logic signed [TRIM_W-1:0] trim;

    modport master (output in, recirc, trim, input out, bit_strobe, frame_start, primed);
    modport slave  (input in, recirc, trim, output out, bit_strobe, frame_start, primed);
`else
    modport master (output in, recirc, input out, bit_strobe, frame_start, primed);
    modport slave  (input in, recirc, output out, bit_strobe, frame_start, primed);
`endif

endinterface

// File: rtl/delay_line_bit_timer.sv
// Bit-period timer: tick counter, mid-period sample point and end-of-period strobe.
// With DELAY_LINE_TRIM_EN the period is TICKS + trim, latched at every strobe.
module delay_line_bit_timer
    import delay_line_pkg::*;
#(
    parameter int TICKS = 154
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef DELAY_LINE_TRIM_EN
    input  logic signed [TRIM_W-1:0] i_trim,
`endif
    output logic                     o_sample,
    output logic                     o_bit_strobe
);

    localparam int              TCW     = ticks_width(TICKS);
    localparam logic [TCW-1:0]  NOMINAL = TCW'(TICKS);

    if (TICKS < 4) begin : g_ticks_chk
        $error("delay_line_bit_timer: TICKS must be at least 4");
    end

    logic [TCW-1:0] r_tc;
    logic [TCW-1:0] w_period;

`ifdef DELAY_LINE_TRIM_EN
    logic [TCW-1:0] r_period;

    // Latching at the strobe keeps the period stable while tc is counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= NOMINAL;
        end else if (o_bit_strobe) begin
            r_period <= NOMINAL + TCW'(i_trim);
        end
    end

    assign w_period = r_period;
`else
    assign w_period = NOMINAL;
`endif

    assign o_bit_strobe = (r_tc == w_period - TCW'(1));
    assign o_sample     = (r_tc == (w_period >> 1) - TCW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tc <= '0;
        end else if (o_bit_strobe) begin
            r_tc <= '0;
        end else begin
            r_tc <= r_tc + TCW'(1);
        end
    end

endmodule

// File: rtl/delay_line_bank.sv
// CHANNELS independent recirculating serial stores of BITS bits each, one bit per period.
// Optional DELAY_LINE_TRIM_EN adds a signed period trim on the interface.
module delay_line_bank
    import delay_line_pkg::*;
#(
    parameter int CLK_FREQ    = 81_000_000,
    parameter int BIT_TIME_NS = 1900,
    parameter int BITS        = 576,
    parameter int CHANNELS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    delay_line_bank_if.slave   bus
);

    localparam int             TICKS    = calc_ticks(CLK_FREQ, BIT_TIME_NS);
    localparam int             PW       = ptr_width(BITS);
    localparam logic [PW-1:0]  PTR_LAST = PW'(BITS - 1);

    if (BITS < 2) begin : g_bits_chk
        $error("delay_line_bank: BITS must be at least 2");
    end
    if (CHANNELS < 1) begin : g_chan_chk
        $error("delay_line_bank: CHANNELS must be at least 1");
    end

    logic                w_sample;
    logic                w_bit_strobe;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] r_rd;
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] w_wdata;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_next;
    logic                r_primed;
    logic [CHANNELS-1:0] r_mem [BITS];

    delay_line_bit_timer #(
        .TICKS        (TICKS)
    ) u_timer (
        .clk          (clk),
        .rst          (reset),
`ifdef DELAY_LINE_TRIM_EN
        .i_trim       (bus.trim),
`endif
        .o_sample     (w_sample),
        .o_bit_strobe (w_bit_strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);
    assign w_wdata    = (bus.recirc & r_out) | (~bus.recirc & r_sync2);

    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_mem[r_ptr] <= w_wdata;
        end
    end

    // The read runs one slot ahead of the write so the bit stored BITS periods
    // earlier is already in r_rd at the strobe that puts it on the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_rd     <= '0;
            r_out    <= '0;
            r_primed <= 1'b0;
        end else begin
            if (w_sample) begin
                r_rd <= r_mem[w_ptr_next];
                if (r_ptr == PTR_LAST) begin
                    r_primed <= 1'b1;
                end
            end
            if (w_bit_strobe) begin
                r_ptr <= w_ptr_next;
                r_out <= r_primed ? r_rd : '0;
            end
        end
    end

    assign bus.out         = r_out;
    assign bus.bit_strobe  = w_bit_strobe;
    assign bus.frame_start = w_bit_strobe && (r_ptr == PTR_LAST);
    assign bus.primed      = r_primed;

endmodule
